tt_sweep_capture: RTL and testbench
===================================

TT_SWEEP_CAPTURE -- requirements
Module: tt_sweep_capture

Interface
REQ-001 Parameter NVARS, default 7: number of function inputs swept; table width TW = 2**NVARS.
REQ-002 Parameter SETTLE, default 1: wait cycles between driving a vector and sampling fn_out (range 0..15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a sweep.
REQ-006 abort  input  1  cancels a sweep in progress.
REQ-007 x  output  NVARS  vector driven to the function under test; x[0] feeds x0 ... x[6] feeds x6.
REQ-008 fn_out  input  1  function output, combinational from x.
REQ-009 busy  output  1  high from the cycle after accepted start until done or abort.
REQ-010 done  output  1  one-cycle pulse when tt is complete and valid.
REQ-011 tt  output  TW  captured truth table; tt[i] = fn_out with x == i.
REQ-012 exp_tt / match  input TW / output 1  golden table and compare result (present only with TT_COMPARE_EN).

Function
REQ-013 FSM states IDLE, DRIVE, SAMPLE, DONE; encoding is free.
REQ-014 IDLE: x = 0, busy = 0; start = 1 -> DRIVE with index = 0, settle counter = SETTLE, tt cleared to 0.
REQ-015 DRIVE: x = index; counter decrements each cycle; at 0 -> SAMPLE (SETTLE = 0 skips DRIVE entirely).
REQ-016 SAMPLE: tt[index] <= fn_out; if index == TW-1 -> DONE, else index+1, counter reload, -> DRIVE.
REQ-017 DONE: done = 1 for exactly one cycle, busy = 0, -> IDLE; tt holds until next accepted start or reset.
REQ-018 Per-vector cost SETTLE+1 cycles; start accepted at cycle 0 -> done at cycle 1 + TW*(SETTLE+1); default 257.
REQ-019 Index counter is NVARS+1 bits; no wrap: terminal check precedes increment.
REQ-020 start while busy or in DONE is ignored; no queuing.
REQ-021 abort has priority over every transition including final SAMPLE: -> IDLE next cycle, done not pulsed, tt = 0.
REQ-022 start and abort in same IDLE cycle: abort wins, sweep not started.
REQ-023 x is registered; it changes only on DRIVE entry, never during SAMPLE.
REQ-024 Hex rendering of tt is MSB first (tt[TW-1] leftmost).

Reset
REQ-025 rst = 1 at any edge, including mid-sweep: state IDLE, x = 0, busy = 0, done = 0, tt = 0, match = 0, counters 0.
REQ-026 rst dominates start and abort.

Configuration
REQ-027 Macro TT_COMPARE_EN defined: exp_tt and match ports exist; match registered in DONE cycle = (tt_final == exp_tt), held until next start/abort/reset.
REQ-028 Macro undefined: ports absent, no comparator logic; all other behaviour identical.

Structure
REQ-029 Shared package tt_pkg holds FSM state enum, NVARS default, SETTLE width constant, TW derivation function.
REQ-030 One sub-module tt_settle_cnt (loadable down-counter with zero flag); everything else in top.

Verification
REQ-031 fn_out = majority(x0,x1,x2), start at t0 -> done at t0+257, tt = 0xE8 repeated 16 times.
REQ-032 fn_out = x6, SETTLE = 3 -> done after 1+128*4 = 513 cycles, tt = 64 ones (MSB) then 64 zeros.
REQ-033 Constant-0 function, abort after 50 cycles -> busy falls next cycle, no done, tt = 0; later start gives full 257-cycle sweep.
REQ-034 rst pulse at vector 100, start 3 cycles later -> tt cleared, sweep restarts at x = 0, correct table.
REQ-035 TT_COMPARE_EN, majority-of-7 function, exp_tt = its golden table -> match = 1; flip exp_tt[5] -> match = 0.
REQ-036 start held high continuously for 600 cycles -> exactly two done pulses, separated by 258 cycles.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep/capture block.
package tt_pkg;

  localparam int NVARS_DEF  = 7;
  localparam int SETTLE_DEF = 1;
  localparam int SETTLE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  function automatic int tw_f(input int nvars);
    return 1 << nvars;
  endfunction

endpackage

// File: rtl/tt_settle_cnt.sv
// Loadable down-counter with zero flag; paces the settle delay per vector.
module tt_settle_cnt
  import tt_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all 2**NVARS input vectors through a combinational function and
// captures its truth table. Optional golden compare under TT_COMPARE_EN.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter  int NVARS  = NVARS_DEF,
  parameter  int SETTLE = SETTLE_DEF,
  localparam int TW     = tw_f(NVARS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [NVARS-1:0] x,
  input  logic             fn_out,
  output logic             busy,
  output logic             done,
`ifdef TT_COMPARE_EN
  input  logic [TW-1:0]    exp_tt,
  output logic             match,
`endif
  output logic [TW-1:0]    tt
);

  localparam int IW = NVARS + 1;
  // Counter holds the remaining DRIVE cycles after the current one, so
  // DRIVE lasts exactly SETTLE cycles before SAMPLE.
  localparam logic [SETTLE_W-1:0] RELOAD =
    (SETTLE == 0) ? '0 : SETTLE_W'(SETTLE - 1);
  localparam state_e ST_FIRST = (SETTLE == 0) ? ST_SAMPLE : ST_DRIVE;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NVARS-1:0] x_q, x_d;
  logic [TW-1:0]    tt_q, tt_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             in_sweep;
`ifdef TT_COMPARE_EN
  logic             match_q, match_d;
`endif

  tt_settle_cnt #(.W(SETTLE_W)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (RELOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign in_sweep = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    tt_d     = tt_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef TT_COMPARE_EN
    match_d  = match_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tt_d     = '0;
          idx_d    = '0;
          x_d      = '0;
          cnt_load = 1'b1;
          state_d  = ST_FIRST;
`ifdef TT_COMPARE_EN
          match_d  = 1'b0;
`endif
        end
      end
      ST_DRIVE: begin
        if (cnt_zero) state_d = ST_SAMPLE;
        else          cnt_dec = 1'b1;
      end
      ST_SAMPLE: begin
        tt_d[idx_q[NVARS-1:0]] = fn_out;
        // Terminal check on the current index, so the counter never wraps.
        if (idx_q == IW'(TW - 1)) begin
          state_d = ST_DONE;
`ifdef TT_COMPARE_EN
          match_d = (tt_d == exp_tt);
`endif
        end else begin
          idx_d    = idx_q + 1'b1;
          x_d      = idx_d[NVARS-1:0];
          cnt_load = 1'b1;
          state_d  = ST_FIRST;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        x_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything decided above, including the final sample.
    if (abort) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      x_d      = '0;
      tt_d     = in_sweep ? '0 : tt_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
`ifdef TT_COMPARE_EN
      match_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      tt_q    <= tt_d;
    end
  end

`ifdef TT_COMPARE_EN
  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match_d;
  end
  assign match = match_q;
`endif

  assign x    = x_q;
  assign tt   = tt_q;
  assign busy = in_sweep;
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Randomized self-checking bench for tt_sweep_capture (SETTLE = 1, 3, 0).
module tb_tt_sweep_capture;

  localparam int NV  = 7;
  localparam int TWB = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           start_v [3];
  logic           abort_v [3];
  logic           fn_v    [3];
  logic           busy_v  [3];
  logic           done_v  [3];
  logic [NV-1:0]  x_v     [3];
  logic [TWB-1:0] tt_v    [3];
  int             mode_v  [3];
  logic [TWB-1:0] rnd_tt;
`ifdef TT_COMPARE_EN
  logic [TWB-1:0] exp_v   [3];
  logic           match_v [3];
`endif

  int checks = 0;
  int passed = 0;

  // Reference functions: 0 maj(x0..x2), 1 x6, 2 const 0, 3 random table, 4 maj of 7
  function automatic logic fref(input int m, input logic [NV-1:0] v, input logic [TWB-1:0] t);
    case (m)
      0:       return (int'(v[0]) + int'(v[1]) + int'(v[2])) >= 2;
      1:       return v[6];
      3:       return t[v];
      4:       return $countones(v) >= 4;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [TWB-1:0] exp_table(input int m, input logic [TWB-1:0] t);
    logic [TWB-1:0] r;
    for (int i = 0; i < TWB; i++) r[i] = fref(m, NV'(i), t);
    return r;
  endfunction

  always_comb
    for (int k = 0; k < 3; k++) fn_v[k] = fref(mode_v[k], x_v[k], rnd_tt);

  tt_sweep_capture #(.NVARS(NV), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .x(x_v[0]),
    .fn_out(fn_v[0]), .busy(busy_v[0]), .done(done_v[0]),
`ifdef TT_COMPARE_EN
    .exp_tt(exp_v[0]), .match(match_v[0]),
`endif
    .tt(tt_v[0]));

  tt_sweep_capture #(.NVARS(NV), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .x(x_v[1]),
    .fn_out(fn_v[1]), .busy(busy_v[1]), .done(done_v[1]),
`ifdef TT_COMPARE_EN
    .exp_tt(exp_v[1]), .match(match_v[1]),
`endif
    .tt(tt_v[1]));

  tt_sweep_capture #(.NVARS(NV), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .x(x_v[2]),
    .fn_out(fn_v[2]), .busy(busy_v[2]), .done(done_v[2]),
`ifdef TT_COMPARE_EN
    .exp_tt(exp_v[2]), .match(match_v[2]),
`endif
    .tt(tt_v[2]));

  // Pulses start, then counts cycles (cycle 1 = first after acceptance) until done.
  task automatic sweep(input int d, input int m, input int restart_at, input int budget,
                       output int dc, output logic [NV-1:0] x1);
    int n;
    mode_v[d] = m;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    n  = 1;
    dc = -1;
    x1 = x_v[d];
    while (n <= budget) begin
      if (done_v[d]) begin
        dc = n;
        break;
      end
      @(negedge clk);
      n++;
      start_v[d] = (n == restart_at);
    end
    start_v[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks += 4;
      if (busy_v[d] !== 1'b0) $display("FAIL reset_busy[%0d] got %b want 0", d, busy_v[d]); else passed++;
      if (done_v[d] !== 1'b0) $display("FAIL reset_done[%0d] got %b want 0", d, done_v[d]); else passed++;
      if (tt_v[d] !== '0)     $display("FAIL reset_tt[%0d] got %h want 0", d, tt_v[d]); else passed++;
      if (x_v[d] !== '0)      $display("FAIL reset_x[%0d] got %h want 0", d, x_v[d]); else passed++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_majority3();
    int dc;
    logic [NV-1:0] x1;
    logic [TWB-1:0] lit;
    lit = {16{8'hE8}};
    sweep(0, 0, 0, 400, dc, x1);
    checks += 4;
    if (dc !== 257) $display("FAIL maj3_latency got %0d want 257", dc); else passed++;
    if (x1 !== '0) $display("FAIL maj3_x_first got %h want 0", x1); else passed++;
    if (tt_v[0] !== lit) $display("FAIL maj3_tt_literal got %h want %h", tt_v[0], lit); else passed++;
    if (tt_v[0] !== exp_table(0, rnd_tt)) $display("FAIL maj3_tt_model got %h", tt_v[0]); else passed++;
    @(negedge clk);
    checks += 4;
    if (done_v[0] !== 1'b0) $display("FAIL done_one_cycle got %b want 0", done_v[0]); else passed++;
    if (busy_v[0] !== 1'b0) $display("FAIL idle_busy got %b want 0", busy_v[0]); else passed++;
    if (tt_v[0] !== lit) $display("FAIL tt_hold got %h want %h", tt_v[0], lit); else passed++;
    if (x_v[0] !== '0) $display("FAIL idle_x got %h want 0", x_v[0]); else passed++;
  endtask

  // Random tables; a second start mid-sweep must be ignored.
  task automatic test_random_tables();
    int dc;
    logic [NV-1:0] x1;
    for (int r = 0; r < 3; r++) begin
      rnd_tt = {$urandom(), $urandom(), $urandom(), $urandom()};
      sweep(0, 3, 100 + r * 37, 400, dc, x1);
      checks += 2;
      if (dc !== 257) $display("FAIL rand%0d_latency got %0d want 257", r, dc); else passed++;
      if (tt_v[0] !== rnd_tt) $display("FAIL rand%0d_tt got %h want %h", r, tt_v[0], rnd_tt); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_settle();
    int dc;
    logic [NV-1:0] x1;
    logic [TWB-1:0] want;
    want = {{64{1'b1}}, {64{1'b0}}};
    sweep(1, 1, 0, 700, dc, x1);
    checks += 2;
    if (dc !== 513) $display("FAIL settle3_latency got %0d want 513", dc); else passed++;
    if (tt_v[1] !== want) $display("FAIL settle3_tt got %h want %h", tt_v[1], want); else passed++;
    rnd_tt = {$urandom(), $urandom(), $urandom(), $urandom()};
    sweep(2, 3, 0, 300, dc, x1);
    checks += 2;
    if (dc !== 129) $display("FAIL settle0_latency got %0d want 129", dc); else passed++;
    if (tt_v[2] !== rnd_tt) $display("FAIL settle0_tt got %h want %h", tt_v[2], rnd_tt); else passed++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int dones;
    int dc;
    logic [NV-1:0] x1;
    rnd_tt = {$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1;
    mode_v[0] = 3;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (49) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    checks += 3;
    if (busy_v[0] !== 1'b0) $display("FAIL abort_busy got %b want 0", busy_v[0]); else passed++;
    if (tt_v[0] !== '0) $display("FAIL abort_tt got %h want 0", tt_v[0]); else passed++;
    if (x_v[0] !== '0) $display("FAIL abort_x got %h want 0", x_v[0]); else passed++;
    dones = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) $display("FAIL abort_no_done got %0d pulses want 0", dones); else passed++;
    sweep(0, 3, 0, 400, dc, x1);
    checks += 2;
    if (dc !== 257) $display("FAIL post_abort_latency got %0d want 257", dc); else passed++;
    if (tt_v[0] !== rnd_tt) $display("FAIL post_abort_tt got %h want %h", tt_v[0], rnd_tt); else passed++;
    @(negedge clk);
  endtask

  task automatic test_abort_final_sample();
    int dones;
    mode_v[0] = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (255) @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b1) $display("FAIL final_sample_busy got %b want 1", busy_v[0]); else passed++;
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    dones = (done_v[0] === 1'b1) ? 1 : 0;
    checks += 2;
    if (busy_v[0] !== 1'b0) $display("FAIL final_abort_busy got %b want 0", busy_v[0]); else passed++;
    if (tt_v[0] !== '0) $display("FAIL final_abort_tt got %h want 0", tt_v[0]); else passed++;
    repeat (5) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) $display("FAIL final_abort_done got %0d pulses want 0", dones); else passed++;
  endtask

  task automatic test_start_abort_same();
    int busy_cnt;
    int dones;
    mode_v[0] = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    busy_cnt = 0;
    dones = 0;
    repeat (300) begin
      if (busy_v[0] === 1'b1) busy_cnt++;
      if (done_v[0] === 1'b1) dones++;
      @(negedge clk);
    end
    checks += 2;
    if (busy_cnt !== 0) $display("FAIL start_abort_busy got %0d cycles want 0", busy_cnt); else passed++;
    if (dones !== 0) $display("FAIL start_abort_done got %0d pulses want 0", dones); else passed++;
  endtask

  task automatic test_reset_mid();
    int dc;
    logic [NV-1:0] x1;
    rnd_tt = {$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1;
    mode_v[0] = 3;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (200) @(negedge clk);
    checks++;
    if (x_v[0] !== NV'(100)) $display("FAIL mid_vector got %0d want 100", x_v[0]); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (busy_v[0] !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy_v[0]); else passed++;
    if (tt_v[0] !== '0) $display("FAIL rst_mid_tt got %h want 0", tt_v[0]); else passed++;
    if (x_v[0] !== '0) $display("FAIL rst_mid_x got %h want 0", x_v[0]); else passed++;
    @(negedge clk);
    sweep(0, 3, 0, 400, dc, x1);
    checks += 3;
    if (x1 !== '0) $display("FAIL restart_x got %h want 0", x1); else passed++;
    if (dc !== 257) $display("FAIL restart_latency got %0d want 257", dc); else passed++;
    if (tt_v[0] !== rnd_tt) $display("FAIL restart_tt got %h want %h", tt_v[0], rnd_tt); else passed++;
    @(negedge clk);
  endtask

  task automatic test_start_held();
    int d1, d2, dones, n;
    mode_v[0] = 0;
    d1 = -1;
    d2 = -1;
    dones = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) begin
        dones++;
        if (d1 < 0) d1 = c; else d2 = c;
      end
    end
    start_v[0] = 1'b0;
    checks += 2;
    if (dones !== 2) $display("FAIL held_pulses got %0d want 2", dones); else passed++;
    if (d2 - d1 !== 258) $display("FAIL held_spacing got %0d want 258", d2 - d1); else passed++;
    n = 0;
    while ((busy_v[0] === 1'b1 || done_v[0] === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks += 2;
    if (n >= 400) $display("FAIL held_drain timed out after %0d cycles", n); else passed++;
    if (tt_v[0] !== exp_table(0, rnd_tt)) $display("FAIL held_tt got %h", tt_v[0]); else passed++;
  endtask

`ifdef TT_COMPARE_EN
  task automatic test_compare();
    int dc;
    logic [NV-1:0] x1;
    exp_v[0] = exp_table(4, rnd_tt);
    sweep(0, 4, 0, 400, dc, x1);
    checks += 2;
    if (match_v[0] !== 1'b1) $display("FAIL match_golden got %b want 1", match_v[0]); else passed++;
    if (tt_v[0] !== exp_table(4, rnd_tt)) $display("FAIL maj7_tt got %h", tt_v[0]); else passed++;
    @(negedge clk);
    checks++;
    if (match_v[0] !== 1'b1) $display("FAIL match_hold got %b want 1", match_v[0]); else passed++;
    exp_v[0][5] = ~exp_v[0][5];
    sweep(0, 4, 0, 400, dc, x1);
    checks++;
    if (match_v[0] !== 1'b0) $display("FAIL match_flipped got %b want 0", match_v[0]); else passed++;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1;
    rnd_tt = '0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      abort_v[k] = 1'b0;
      mode_v[k]  = 0;
`ifdef TT_COMPARE_EN
      exp_v[k]   = '0;
`endif
    end
    test_reset();
    test_majority3();
    test_random_tables();
    test_settle();
    test_abort();
    test_abort_final_sample();
    test_start_abort_same();
    test_reset_mid();
    test_start_held();
`ifdef TT_COMPARE_EN
    test_compare();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
